simple_phase_ctrl: RTL and testbench

//  Multicycle phase sequencer for the 16-bit SIMPLE datapath. Walks each instruction

---
 rtl/simple_phase_ctrl_if.sv | 26 ++
 rtl/simple_phase_ctrl.sv | 114 +++++++++++
 tb/tb_simple_phase_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/simple_phase_ctrl_if.sv
// Instruction/memory/branch handshake and status bundle between the phase
// sequencer (slave) and the surrounding datapath or bench (master).
interface simple_phase_ctrl_if;
  logic        start;
  logic [15:0] command;
  logic        mem_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [4:0]  stage_en;
  logic        running;
  logic        halted;
  logic        fault;
  logic [15:0] retired;

  modport master (
    output start, command, mem_ready, branch_taken, branch_target,
    input  pc, ir, stage_en, running, halted, fault, retired
  );

  modport slave (
    input  start, command, mem_ready, branch_taken, branch_target,
    output pc, ir, stage_en, running, halted, fault, retired
  );
endinterface

// File: rtl/simple_phase_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit SIMPLE datapath.
// Owns pc and ir, stalls MEM on the data-memory handshake, stops on HLT or timeout.
module simple_phase_ctrl #(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
  input logic           clock,
  input logic           reset_n,
  simple_phase_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_retired;
  logic [7:0]  r_wait_cnt;
  logic        r_br_taken;
  logic [15:0] r_br_target;

  logic        w_is_hlt;
  logic        w_is_mem;
  logic        w_idle_like;
  logic [4:0]  w_stage_en;

  assign w_is_hlt    = (r_ir[15:14] == 2'b11) && (r_ir[7:4] == 4'hF);
  assign w_is_mem    = (r_ir[15:14] == 2'b00) || (r_ir[15:14] == 2'b01);
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_FAULT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stage_en  = 5'b00000;
    case (r_state)
      S_IDLE, S_HALT, S_FAULT: begin
        if (bus.start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_stage_en  = 5'b00001;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_stage_en  = 5'b00010;
        w_state_nxt = w_is_hlt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_stage_en  = 5'b00100;
        w_state_nxt = S_MEM;
      end
      S_MEM: begin
        w_stage_en = 5'b01000;
        // mem_ready on the last allowed wait cycle still completes the access
        if (!w_is_mem || bus.mem_ready)             w_state_nxt = S_WB;
        else if (r_wait_cnt == MEM_TIMEOUT - 8'd1)  w_state_nxt = S_FAULT;
      end
      S_WB: begin
        w_stage_en  = 5'b10000;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= PC_RESET;
      r_ir        <= 16'h0000;
      r_retired   <= 16'h0000;
      r_wait_cnt  <= 8'd0;
      r_br_taken  <= 1'b0;
      r_br_target <= 16'h0000;
    end else begin
      if (w_idle_like && bus.start) r_pc <= PC_RESET;
      if (r_state == S_FETCH) r_ir <= bus.command;
      if (r_state == S_EXEC) begin
        r_br_taken  <= bus.branch_taken;
        r_br_target <= bus.branch_target;
        r_wait_cnt  <= 8'd0;
      end
      if ((r_state == S_MEM) && w_is_mem && !bus.mem_ready) r_wait_cnt <= r_wait_cnt + 8'd1;
      if (r_state == S_WB) begin
        r_pc      <= r_br_taken ? r_br_target : r_pc + 16'd1;
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign bus.pc       = r_pc;
  assign bus.ir       = r_ir;
  assign bus.stage_en = w_stage_en;
  assign bus.running  = (w_stage_en != 5'b00000);
  assign bus.halted   = (r_state == S_HALT);
  assign bus.fault    = (r_state == S_FAULT);
  assign bus.retired  = r_retired;

endmodule

// File: tb/tb_simple_phase_ctrl.sv
// Directed bench for simple_phase_ctrl: reset, ALU stream, load stall, branch,
// HLT and memory timeout, each with hand-computed expected values.
module tb_simple_phase_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  simple_phase_ctrl_if bus();

  simple_phase_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    bus.start = 1'b0; bus.command = 16'h0000; bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
    @(negedge clock);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.command = 16'h0000;
    start_pulse();
    cyc(); cyc(); cyc();
    tests_run++;
    if (bus.stage_en !== 5'b01000) begin tests_failed++;
      $display("FAIL reset_pre_mem: stage_en=%b required 01000", bus.stage_en); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.stage_en !== 5'b0 || bus.running !== 1'b0 || bus.halted !== 1'b0 ||
        bus.fault !== 1'b0 || bus.pc !== 16'h0 || bus.ir !== 16'h0 || bus.retired !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_async: stage_en=%b run=%b halt=%b fault=%b pc=%h ir=%h ret=%h required all zero",
               bus.stage_en, bus.running, bus.halted, bus.fault, bus.pc, bus.ir, bus.retired);
    end
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    tests_run++;
    if (bus.stage_en !== 5'b0) begin tests_failed++;
      $display("FAIL reset_idle: stage_en=%b required 00000", bus.stage_en); end
    start_pulse();
    tests_run++;
    if (bus.stage_en !== 5'b00001 || bus.running !== 1'b1) begin tests_failed++;
      $display("FAIL reset_start: stage_en=%b running=%b required 00001/1", bus.stage_en, bus.running); end
  endtask

  task automatic test_alu_stream();
    logic [4:0] exp_en;
    do_reset();
    bus.command = 16'hC000;
    start_pulse();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) cyc();
      exp_en = 5'b00001 << (i % 5);
      tests_run++;
      if (bus.stage_en !== exp_en || bus.pc !== 16'(i / 5)) begin tests_failed++;
        $display("FAIL alu_cycle%0d: stage_en=%b pc=%h required %b/%h", i + 1, bus.stage_en, bus.pc, exp_en, 16'(i / 5)); end
    end
    cyc();
    tests_run++;
    if (bus.retired !== 16'd3 || bus.pc !== 16'd3 || bus.stage_en !== 5'b00001) begin tests_failed++;
      $display("FAIL alu_retired: retired=%0d pc=%h stage_en=%b required 3/0003/00001", bus.retired, bus.pc, bus.stage_en); end
  endtask

  task automatic test_load_stall();
    logic [4:0] exp_en [9] = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd8, 5'd8, 5'd8, 5'd16, 5'd1};
    do_reset();
    bus.command = 16'h0805;
    start_pulse();
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) cyc();
      bus.mem_ready = (c == 7);
      tests_run++;
      if (bus.stage_en !== exp_en[c-1]) begin tests_failed++;
        $display("FAIL load_cycle%0d: stage_en=%b required %b", c, bus.stage_en, exp_en[c-1]); end
    end
    tests_run++;
    if (bus.pc !== 16'd1 || bus.retired !== 16'd1 || bus.ir !== 16'h0805) begin tests_failed++;
      $display("FAIL load_done: pc=%h retired=%0d ir=%h required 0001/1/0805", bus.pc, bus.retired, bus.ir); end
  endtask

  task automatic test_branch();
    do_reset();
    bus.command = 16'hC000;
    start_pulse();
    cyc(); cyc();
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0040;
    cyc();
    bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
    cyc(); cyc();
    tests_run++;
    if (bus.pc !== 16'h0040 || bus.stage_en !== 5'b00001) begin tests_failed++;
      $display("FAIL branch_taken: pc=%h stage_en=%b required 0040/00001", bus.pc, bus.stage_en); end
    cyc();
    bus.branch_taken = 1'b1; bus.branch_target = 16'h1234;
    cyc();
    bus.branch_taken = 1'b0;
    cyc(); cyc(); cyc();
    tests_run++;
    if (bus.pc !== 16'h0041 || bus.retired !== 16'd2) begin tests_failed++;
      $display("FAIL branch_decode_only: pc=%h retired=%0d required 0041/2", bus.pc, bus.retired); end
  endtask

  task automatic test_hlt();
    do_reset();
    bus.command = 16'hC000;
    start_pulse();
    cyc(); cyc(); cyc(); cyc(); cyc();
    bus.command = 16'hC0F0;
    cyc();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    tests_run++;
    if (bus.halted !== 1'b1 || bus.stage_en !== 5'b0 || bus.running !== 1'b0 ||
        bus.pc !== 16'd1 || bus.retired !== 16'd1) begin tests_failed++;
      $display("FAIL hlt_halt: halted=%b stage_en=%b running=%b pc=%h retired=%0d required 1/00000/0/0001/1",
               bus.halted, bus.stage_en, bus.running, bus.pc, bus.retired); end
    cyc(); cyc();
    tests_run++;
    if (bus.halted !== 1'b1 || bus.pc !== 16'd1) begin tests_failed++;
      $display("FAIL hlt_hold: halted=%b pc=%h required 1/0001", bus.halted, bus.pc); end
    bus.command = 16'hC000;
    start_pulse();
    tests_run++;
    if (bus.halted !== 1'b0 || bus.pc !== 16'h0000 || bus.stage_en !== 5'b00001 || bus.retired !== 16'd1) begin tests_failed++;
      $display("FAIL hlt_restart: halted=%b pc=%h stage_en=%b retired=%0d required 0/0000/00001/1",
               bus.halted, bus.pc, bus.stage_en, bus.retired); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.command = 16'h4000;
    start_pulse();
    for (int c = 2; c <= 258; c++) cyc();
    tests_run++;
    if (bus.stage_en !== 5'b01000 || bus.fault !== 1'b0) begin tests_failed++;
      $display("FAIL timeout_last_wait: stage_en=%b fault=%b required 01000/0", bus.stage_en, bus.fault); end
    cyc();
    tests_run++;
    if (bus.fault !== 1'b1 || bus.stage_en !== 5'b0 || bus.running !== 1'b0 || bus.retired !== 16'd0) begin tests_failed++;
      $display("FAIL timeout_fault: fault=%b stage_en=%b running=%b retired=%0d required 1/00000/0/0",
               bus.fault, bus.stage_en, bus.running, bus.retired); end
    start_pulse();
    tests_run++;
    if (bus.fault !== 1'b0 || bus.pc !== 16'h0 || bus.stage_en !== 5'b00001) begin tests_failed++;
      $display("FAIL timeout_restart: fault=%b pc=%h stage_en=%b required 0/0000/00001", bus.fault, bus.pc, bus.stage_en); end
    for (int c = 2; c <= 258; c++) cyc();
    bus.mem_ready = 1'b1;
    cyc();
    bus.mem_ready = 1'b0;
    tests_run++;
    if (bus.stage_en !== 5'b10000 || bus.fault !== 1'b0) begin tests_failed++;
      $display("FAIL timeout_final_ready: stage_en=%b fault=%b required 10000/0", bus.stage_en, bus.fault); end
    cyc();
    tests_run++;
    if (bus.pc !== 16'd1 || bus.retired !== 16'd1 || bus.stage_en !== 5'b00001) begin tests_failed++;
      $display("FAIL timeout_retire: pc=%h retired=%0d stage_en=%b required 0001/1/00001", bus.pc, bus.retired, bus.stage_en); end
  endtask

  initial begin
    bus.start = 1'b0; bus.command = 16'h0000; bus.mem_ready = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
    test_reset();
    test_alu_stream();
    test_load_stall();
    test_branch();
    test_hlt();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
